// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: select encodings, flag bit
// positions and the operand width of the external ALU.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Bit positions inside the 4-bit flag vector {zero, negative, carry, overflow}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo NREQ) wins. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int best_d;
  int d;

  // Pick the requesting index with the smallest circular distance from ptr
  always_comb begin
    best_d  = NREQ;
    d       = 0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(ptr) + NREQ) % NREQ;
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = IDW'(i);
      end
    end
    gnt = (best_d < NREQ) ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one external combinational ALU among NREQ
// requesters. Two-stage pipeline: an issue register that drives the ALU
// inputs, and a response register that captures the ALU result, flags and
// the requester id. Backpressure on the response side stalls both stages.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ALU_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*2-1:0]        req_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [1:0]               alu_sel,
  input  logic [W-1:0]             alu_y,
  input  logic [3:0]               alu_flags,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_y,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;

  logic [W-1:0]    win_a;
  logic [W-1:0]    win_b;
  logic [1:0]      win_sel;

  logic            vld_p1;
  logic [W-1:0]    a_p1;
  logic [W-1:0]    b_p1;
  logic [1:0]      sel_p1;
  logic [IDW-1:0]  id_p1;

  logic            vld_p2;
  logic [W-1:0]    y_p2;
  logic [3:0]      flags_p2;
  logic [IDW-1:0]  id_p2;

  logic            iss_adv;
  logic            iss_load;
  logic            xfer;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The issue op moves on when the response slot is empty or being drained;
  // the issue slot can take a new op when it is empty or moving on. While
  // reset is asserted no grant is offered even though the slot is empty.
  assign iss_adv   = vld_p1 && (!vld_p2 || rsp_ready);
  assign iss_load  = !vld_p1 || iss_adv;
  assign req_ready = (rst_n && iss_load) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  // Route the winning requester's operands toward the issue register
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_a   = req_a[i*W +: W];
        win_b   = req_b[i*W +: W];
        win_sel = req_sel[i*2 +: 2];
      end
    end
  end

  // Round-robin pointer: move just past the requester that transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // ---- stage p1: issue register, drives the ALU directly ----
  // Load the granted op whenever the issue slot is free or advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      sel_p1 <= '0;
      id_p1  <= '0;
    end else if (iss_load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        a_p1   <= win_a;
        b_p1   <= win_b;
        sel_p1 <= win_sel;
        id_p1  <= gnt_idx;
      end
    end
  end

  assign alu_a   = a_p1;
  assign alu_b   = b_p1;
  assign alu_sel = sel_p1;

  // ---- stage p2: response register, captures ALU result and flags ----
  // Capture on advance; otherwise drop the response once it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      y_p2     <= '0;
      flags_p2 <= '0;
      id_p2    <= '0;
    end else if (iss_adv) begin
      vld_p2   <= 1'b1;
      y_p2     <= alu_y;
      flags_p2 <= alu_flags;
      id_p2    <= id_p1;
    end else if (rsp_ready) begin
      vld_p2   <= 1'b0;
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_y     = y_p2;
  assign rsp_flags = flags_p2;
  assign rsp_id    = id_p2;
  assign busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: directed scenarios followed by randomized
// traffic, with a scoreboard of expected responses drained by a monitor.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ*2-1:0]   req_sel;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [1:0]          alu_sel;
  logic [W-1:0]        alu_y;
  logic [3:0]          alu_flags;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_y;
  logic [3:0]          rsp_flags;
  logic                busy;

  always #5 clk = ~clk;

  alu_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_flags (alu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  // External ALU the scheduler drives
  logic [W:0] alu_t;
  always_comb begin
    alu_t     = '0;
    alu_flags = '0;
    case (alu_sel)
      ALU_ADD: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flags[FLG_V] = (alu_a[W-1] == alu_b[W-1]) && (alu_t[W-1] != alu_a[W-1]);
      end
      ALU_SUB: begin
        alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
        alu_flags[FLG_V] = (alu_a[W-1] != alu_b[W-1]) && (alu_t[W-1] != alu_a[W-1]);
      end
      ALU_AND: alu_t = {1'b0, alu_a & alu_b};
      default: alu_t = {1'b0, alu_a | alu_b};
    endcase
    alu_y            = alu_t[W-1:0];
    alu_flags[FLG_C] = alu_t[W];
    alu_flags[FLG_Z] = (alu_y == '0);
    alu_flags[FLG_N] = alu_y[W-1];
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   y;
    logic [3:0]     f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: round-robin pointer, op waiting at issue,
  // op presented at the response port, winner of the current cycle.
  int   m_ptr = 0;
  bit   m_s1 = 1'b0;
  bit   m_s2 = 1'b0;
  int   m_win = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected ALU response from integer arithmetic on the operand values
  function automatic logic [7:0] ref_alu(input int a, input int b, input int sel);
    int r, sa, sb2, sr;
    bit c, v;
    logic [3:0] y;
    sa  = (a >= 8) ? a - 16 : a;
    sb2 = (b >= 8) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      0: begin r = a + b;      c = (r > 15);  sr = sa + sb2; v = (sr > 7) || (sr < -8); end
      1: begin r = a - b + 16; c = (a >= b);  sr = sa - sb2; v = (sr > 7) || (sr < -8); end
      2: r = a & b;
      default: r = a | b;
    endcase
    r = r % 16;
    y = 4'(r);
    return {y, (r == 0), (r >= 8), c, v};
  endfunction

  task automatic set_op(input int i, input int a, input int b, input int sel);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_sel[i*2 +: 2] = 2'(sel);
  endtask

  // Compare the DUT's handshake outputs with the model and advance the model
  task automatic model_cycle();
    bit can_load, adv;
    logic [NREQ-1:0] exp_rdy;
    logic [7:0] r;
    exp_t e;
    int idx;
    m_win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (m_win < 0 && req_valid[idx]) m_win = idx;
    end
    can_load = !m_s1 || !m_s2 || rsp_ready;
    if (!can_load) m_win = -1;
    exp_rdy = '0;
    if (m_win >= 0) exp_rdy[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_s1 || m_s2));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
    adv  = m_s1 && (!m_s2 || rsp_ready);
    m_s2 = adv || (m_s2 && !rsp_ready);
    m_s1 = (m_win >= 0) || (m_s1 && !adv);
    if (m_win >= 0) begin
      r = ref_alu(int'(req_a[m_win*W +: W]), int'(req_b[m_win*W +: W]),
                  int'(req_sel[m_win*2 +: 2]));
      e.id = IDW'(m_win);
      e.y  = r[7:4];
      e.f  = r[3:0];
      sb.push_back(e);
      m_ptr = (m_win + 1) % NREQ;
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic rdy);
    req_valid = v;
    rsp_ready = rdy;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_alu_in", 32'({alu_a, alu_b, alu_sel}), 32'(0));
    chk("rst_rsp_data", 32'({rsp_id, rsp_y, rsp_flags}), 32'(0));
    sb.delete();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a response is taken and checks
  // that a stalled response stays put
  bit             held = 1'b0;
  logic [IDW-1:0] h_id;
  logic [W-1:0]   h_y;
  logic [3:0]     h_f;
  exp_t           me;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 32'(rsp_valid), 32'(1));
        chk("stall_data", 32'({rsp_id, rsp_y, rsp_flags}), 32'({h_id, h_y, h_f}));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d with no pending op at %0t", rsp_id, $time);
        end else begin
          me = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(me.id));
          chk("rsp_y", 32'(rsp_y), 32'(me.y));
          chk("rsp_flags", 32'(rsp_flags), 32'(me.f));
        end
      end
      held = rsp_valid && !rsp_ready;
      h_id = rsp_id;
      h_y  = rsp_y;
      h_f  = rsp_flags;
    end
  end

  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] v;

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    pend = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single add from requester 2: 15 + 1 wraps to zero with carry
    set_op(2, 15, 1, 0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    chk("add_valid", 32'(rsp_valid), 32'(1));
    chk("add_id", 32'(rsp_id), 32'(2));
    chk("add_y", 32'(rsp_y), 32'(0));
    chk("add_flags", 32'(rsp_flags), 32'(4'b1010));
    step(4'b0000, 1'b1);

    // All requesters from reset, then pointer wrap priority 0 over 3
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, i + 3, 2 * i + 1, i);
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Backpressure: two ops absorbed, third blocked, outputs frozen
    set_op(0, 5, 6, 2);
    set_op(1, 9, 3, 3);
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b0);
    chk("bp_ready", 32'(req_ready), 32'(0));
    chk("bp_id", 32'(rsp_id), 32'(0));
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Subtract 7 - (-1): signed overflow into negative
    set_op(1, 7, 15, 1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    chk("sub_y", 32'(rsp_y), 32'(4'b1000));
    chk("sub_flags", 32'(rsp_flags), 32'(4'b0101));
    step(4'b0000, 1'b1);

    // Reset one cycle after an accept; the op must vanish
    set_op(2, 3, 4, 0);
    step(4'b0100, 1'b1);
    req_valid = 4'b1111;
    do_reset();
    step(4'b1111, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Randomized traffic with random response backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && ($urandom_range(3) != 0)) begin
          v[i] = 1'b1;
        end else begin
          v[i] = ($urandom_range(1) == 1);
          set_op(i, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)));
        end
      end
      step(v, ($urandom_range(9) < 7));
      for (int i = 0; i < NREQ; i++) pend[i] = v[i] && (m_win != i);
    end
    for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
